cmd_dispatcher: RTL and testbench

CMD_DISPATCHER -- requirements
Module: cmd_dispatcher

---
 rtl/cmd_dispatcher.sv | 139 +++++++++++++
 tb/tb_cmd_dispatcher.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_dispatcher.sv
// Command FIFO feeding a broadcast bus; flush words (action 4'hF) wait for vertical blanking, at most one per frame.
// Define CMD_DISPATCH_STATUS_EN to build the status register and sticky overflow flag.
module cmd_dispatcher #(
  parameter int         FIFO_DEPTH   = 16,
  parameter logic [9:0] VBLANK_START = 10'd480,
  parameter logic [9:0] VTOTAL       = 10'd525
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        chipselect,
  input  logic        write,
  input  logic        read,
  input  logic        address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [9:0]  vcount,
  output logic [31:0] cmd_out,
  output logic        buffer_sel,
  output logic        flip_pulse
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ISSUE       = 2'd0,
    WAIT_VBLANK = 2'd1,
    HOLD_FRAME  = 2'd2
  } state_t;

  state_t        state;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [31:0]   head;
  logic          not_empty;
  logic          full;
  logic          push_req;
  logic          push;
  logic          pop;
  logic          head_flush;
  logic          in_vblank;

  assign head       = mem[rd_ptr];
  assign not_empty  = (count != '0);
  assign full       = (count == CW'(FIFO_DEPTH));
  assign push_req   = chipselect && write && !address;
  assign push       = push_req && !full;
  assign head_flush = not_empty && (head[20:17] == 4'hF);
  assign in_vblank  = (vcount >= VBLANK_START) && (vcount < VTOTAL);

  // In WAIT_VBLANK the head is always the flush word that caused the stall.
  always_comb begin
    pop = 1'b0;
    case (state)
      ISSUE, HOLD_FRAME: pop = not_empty && !head_flush;
      WAIT_VBLANK:       pop = not_empty && in_vblank;
      default:           pop = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= writedata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ISSUE;
      cmd_out    <= 32'h0;
      buffer_sel <= 1'b0;
      flip_pulse <= 1'b0;
    end else begin
      cmd_out    <= pop ? head : 32'h0;
      flip_pulse <= 1'b0;
      case (state)
        ISSUE: begin
          if (head_flush) state <= WAIT_VBLANK;
        end
        WAIT_VBLANK: begin
          if (pop) begin
            flip_pulse <= 1'b1;
            buffer_sel <= head[13];
            state      <= HOLD_FRAME;
          end
        end
        HOLD_FRAME: begin
          // Leaving only once active video is seen guarantees the next flush lands in a later frame.
          if (vcount < VBLANK_START) state <= ISSUE;
        end
        default: state <= ISSUE;
      endcase
    end
  end

`ifdef CMD_DISPATCH_STATUS_EN
  logic       overflow;
  logic [4:0] count_stat;
  logic       status_rd;

  assign count_stat = 5'(count);
  assign status_rd  = chipselect && read && address;

  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= 32'h0;
      overflow <= 1'b0;
    end else begin
      if (chipselect && read)
        readdata <= address ? {24'h0, count_stat, overflow, state} : 32'h0;
      if (push_req && full)
        overflow <= 1'b1;
      else if (status_rd)
        overflow <= 1'b0;
    end
  end
`else
  logic status_unused;
  assign status_unused = read;
  assign readdata      = 32'h0;
`endif

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Directed vectors and a randomized queue-based scoreboard for cmd_dispatcher.
module tb_cmd_dispatcher;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        chipselect = 1'b0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic        address = 1'b0;
  logic [31:0] writedata = 32'h0;
  logic [9:0]  vcount = 10'd0;
  logic [31:0] readdata;
  logic [31:0] cmd_out;
  logic        buffer_sel;
  logic        flip_pulse;

  int checks = 0;
  int errors = 0;
  logic [31:0] model_q[$];
  int last_flush_frame = -1;

  typedef struct {
    logic [31:0] word;
    logic [9:0]  vc;
    logic [31:0] exp_out;
    logic        exp_flip;
  } vec_t;
  vec_t tbl[5];

  cmd_dispatcher dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
    .read(read), .address(address), .writedata(writedata), .readdata(readdata),
    .vcount(vcount), .cmd_out(cmd_out), .buffer_sel(buffer_sel), .flip_pulse(flip_pulse)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; chipselect = 1'b0; write = 1'b0; read = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic push(input logic [31:0] w);
    chipselect = 1'b1; write = 1'b1; address = 1'b0; writedata = w;
    tick();
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic rd(input logic addr, output logic [31:0] v);
    chipselect = 1'b1; read = 1'b1; address = addr;
    tick();
    v = readdata;
    chipselect = 1'b0; read = 1'b0; address = 1'b0;
  endtask

  // State bits are masked: only count and overflow have defined values.
  task automatic chk_status(input string name, input logic [31:0] v, input logic [4:0] cnt, input logic ovf);
`ifdef CMD_DISPATCH_STATUS_EN
    chk(name, v & 32'hFFFF_FFFC, {24'h0, cnt, ovf, 2'b00});
`else
    chk(name, v, 32'h0);
`endif
  endtask

  task automatic quiet(input string name, input int n);
    logic [31:0] seen;
    logic        fseen;
    seen = 32'h0; fseen = 1'b0;
    repeat (n) begin
      tick();
      seen  = seen | cmd_out;
      fseen = fseen | flip_pulse;
    end
    chk(name, seen, 32'h0);
    chk({name, "_flip"}, 32'(fseen), 32'h0);
  endtask

  task automatic wait_out(input string name, input logic [31:0] exp, input logic exp_flip, input int budget);
    for (int i = 0; i < budget && cmd_out == 32'h0; i++) tick();
    chk(name, cmd_out, exp);
    chk({name, "_flip"}, 32'(flip_pulse), 32'(exp_flip));
  endtask

  task automatic observe(input logic [9:0] vc, input int fr);
    logic [31:0] exp;
    if (cmd_out != 32'h0) begin
      if (model_q.size() == 0) begin
        chk("rnd_unexpected", cmd_out, 32'h0);
      end else begin
        exp = model_q.pop_front();
        chk("rnd_word", cmd_out, exp);
        chk("rnd_flip", 32'(flip_pulse), 32'(exp[20:17] == 4'hF));
        if (exp[20:17] == 4'hF) begin
          chk("rnd_flush_in_vblank", 32'(vc >= 10'd480 && vc < 10'd525), 32'd1);
          chk("rnd_one_per_frame", 32'(fr == last_flush_frame), 32'd0);
          last_flush_frame = fr;
          chk("rnd_buffer_sel", 32'(buffer_sel), 32'(exp[13]));
        end
      end
    end else begin
      chk("rnd_idle_flip", 32'(flip_pulse), 32'h0);
    end
  endtask

  function automatic logic [31:0] gen_word(input int seq);
    logic [3:0] act;
    logic [31:0] r;
    r   = $urandom;
    act = ($urandom_range(0, 199) == 0) ? 4'hF : 4'($urandom_range(0, 14));
    return {r[31:26], r[25:21], act, r[16:14], r[13], 13'(seq)};
  endfunction

  initial begin
    logic [31:0] v;
    logic [9:0]  vv;
    logic [9:0]  vc_app;
    int          frame;
    int          fr_app;
    int          seq;

    tbl[0] = '{32'h3C02_0010, 10'd100, 32'h3C02_0010, 1'b0};
    tbl[1] = '{32'hFFFD_FFFF, 10'd480, 32'hFFFD_FFFF, 1'b0};
    tbl[2] = '{32'h0000_0001, 10'd524, 32'h0000_0001, 1'b0};
    tbl[3] = '{32'h001C_0000, 10'd479, 32'h001C_0000, 1'b0};
    tbl[4] = '{32'h8000_0000, 10'd0,   32'h8000_0000, 1'b0};

    do_reset();
    chk("rst_cmd_out", cmd_out, 32'h0);
    chk("rst_buffer_sel", 32'(buffer_sel), 32'h0);
    chk("rst_flip", 32'(flip_pulse), 32'h0);
    chk("rst_readdata", readdata, 32'h0);

    // Non-flush words: two-cycle latency, single-cycle presence, independent of vcount.
    for (int i = 0; i < 5; i++) begin
      vcount = tbl[i].vc;
      push(tbl[i].word);
      chk("tbl_pre", cmd_out, 32'h0);
      tick();
      chk("tbl_out", cmd_out, tbl[i].exp_out);
      chk("tbl_flip", 32'(flip_pulse), 32'(tbl[i].exp_flip));
      tick();
      chk("tbl_post", cmd_out, 32'h0);
    end

    // Flush waits for blanking.
    do_reset();
    vcount = 10'd200;
    push(32'h001E_2000);
    quiet("flush_stall_active", 20);
    vcount = 10'd479;
    quiet("flush_stall_479", 3);
    vcount = 10'd480;
    wait_out("flush_issue", 32'h001E_2000, 1'b1, 4);
    chk("flush_buffer_sel", 32'(buffer_sel), 32'd1);
    tick();
    chk("flush_after", cmd_out, 32'h0);
    chk("flush_after_flip", 32'(flip_pulse), 32'h0);
    chk("flush_after_bsel", 32'(buffer_sel), 32'd1);

    // Two flushes in one blanking interval; a plain word between them still flows.
    do_reset();
    vcount = 10'd490;
    push(32'h041E_2001);
    push(32'h0802_0005);
    push(32'h041E_0002);
    wait_out("two_flush_first", 32'h041E_2001, 1'b1, 4);
    chk("two_flush_bsel1", 32'(buffer_sel), 32'd1);
    tick();
    chk("hold_passes_nonflush", cmd_out, 32'h0802_0005);
    quiet("two_flush_same_frame", 30);
    vcount = 10'd524;
    quiet("two_flush_524", 1);
    vcount = 10'd0;
    quiet("two_flush_line0", 3);
    vcount = 10'd100;
    quiet("two_flush_active", 5);
    vcount = 10'd480;
    wait_out("two_flush_second", 32'h041E_0002, 1'b1, 4);
    chk("two_flush_bsel0", 32'(buffer_sel), 32'd0);

    // Overflow while stalled; the 17th push is dropped.
    do_reset();
    vcount = 10'd100;
    push(32'h001E_2000);
    for (int i = 1; i <= 16; i++) push(32'h0C00_0100 | 32'(i));
    tick();
    rd(1'b1, v);
    chk_status("ovf_status1", v, 5'd16, 1'b1);
    rd(1'b1, v);
    chk_status("ovf_status2", v, 5'd16, 1'b0);
    rd(1'b0, v);
    chk("rd_addr0", v, 32'h0);
    vcount = 10'd480;
    wait_out("ovf_flush", 32'h001E_2000, 1'b1, 4);
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk("ovf_drain", cmd_out, 32'h0C00_0100 | 32'(i));
    end
    quiet("ovf_dropped_absent", 10);
    rd(1'b1, v);
    chk_status("ovf_status_empty", v, 5'd0, 1'b0);

    // Reset mid-stall discards queued words.
    do_reset();
    vcount = 10'd480;
    push(32'h001E_2000);
    wait_out("rst_pre_flush", 32'h001E_2000, 1'b1, 4);
    chk("rst_pre_bsel", 32'(buffer_sel), 32'd1);
    vcount = 10'd100;
    repeat (3) tick();
    push(32'h001E_0000);
    for (int i = 1; i <= 4; i++) push(32'h1000_0200 | 32'(i));
    quiet("rst_stall_quiet", 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_mid_cmd_out", cmd_out, 32'h0);
    chk("rst_mid_bsel", 32'(buffer_sel), 32'h0);
    chk("rst_mid_flip", 32'(flip_pulse), 32'h0);
    rd(1'b1, v);
    chk_status("rst_mid_status", v, 5'd0, 1'b0);
    vcount = 10'd480;
    quiet("rst_mid_nothing_left", 10);
    push(32'h2000_0777);
    chk("rst_post_pre", cmd_out, 32'h0);
    tick();
    chk("rst_post_word", cmd_out, 32'h2000_0777);

    // Randomized traffic with a free-running line counter.
    do_reset();
    model_q.delete();
    last_flush_frame = -1;
    vv = 10'd0; frame = 0; seq = 1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      vcount = vv; vc_app = vv; fr_app = frame;
      if (model_q.size() < DEPTH - 1 && $urandom_range(0, 2) == 0) begin
        v = gen_word(seq);
        seq++;
        chipselect = 1'b1; write = 1'b1; address = 1'b0; writedata = v;
        model_q.push_back(v);
      end
      tick();
      chipselect = 1'b0; write = 1'b0;
      observe(vc_app, fr_app);
      if (vv == 10'd524) begin vv = 10'd0; frame++; end else vv = vv + 10'd1;
    end
    for (int cyc = 0; cyc < 9000 && model_q.size() > 0; cyc++) begin
      vcount = vv; vc_app = vv; fr_app = frame;
      tick();
      observe(vc_app, fr_app);
      if (vv == 10'd524) begin vv = 10'd0; frame++; end else vv = vv + 10'd1;
    end
    chk("rnd_drain_empty", 32'(model_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
